// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM generator.
// Mode/direction encodings, default widths and the duty-bus slice helper.
package pwm_pkg;

    localparam int DEF_WIDTH      = 12;
    localparam int DEF_CHANNELS   = 4;
    localparam int DEF_PRESCALE_W = 8;
    localparam int DEF_DEADTIME_W = 4;

    localparam logic [0:0] MODE_EDGE   = 1'b0;
    localparam logic [0:0] MODE_CENTER = 1'b1;
    localparam logic [0:0] DIR_UP      = 1'b0;
    localparam logic [0:0] DIR_DOWN    = 1'b1;

    // Ceiling sizes for the generic slice helper; callers zero-extend into this bus.
    localparam int SLICE_MAX_W  = 32;
    localparam int SLICE_MAX_CH = 32;
    localparam int SLICE_BUS_W  = SLICE_MAX_W * SLICE_MAX_CH;
    localparam int SLICE_AW     = $clog2(SLICE_BUS_W);
    localparam int SLICE_WW     = $clog2(SLICE_MAX_W);

    function automatic logic [SLICE_MAX_W-1:0] duty_slice(
        input logic [SLICE_BUS_W-1:0] bus,
        input int unsigned            idx,
        input int unsigned            w
    );
        logic [SLICE_MAX_W-1:0] r;
        r = '0;
        for (int unsigned b = 0; b < SLICE_MAX_W; b++) begin
            if (b < w) r[SLICE_WW'(b)] = bus[SLICE_AW'(idx * w + b)];
        end
        return r;
    endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Complementary-pair generator with dead-time insertion for one PWM channel.
// Instantiated only when PWM_DEADTIME_EN is defined.
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DEADTIME_W = DEF_DEADTIME_W
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic                  enable_i,
    input  logic [DEADTIME_W-1:0] deadtime_i,
    input  logic                  pwm_i,
    output logic                  p_o,
    output logic                  n_o
);

    localparam logic [DEADTIME_W-1:0] DT_ONE = DEADTIME_W'(1);

    logic                  p_q, p_d;
    logic                  n_q, n_d;
    logic [DEADTIME_W-1:0] dly_q, dly_d;
    logic                  want_p, want_n;

    assign want_p = pwm_i;
    assign want_n = enable_i && !pwm_i;

    // A leg falls immediately; the opposite leg rises only once the gap has elapsed,
    // so a request that flips back inside the gap never reaches the pin.
    always_comb begin
        p_d   = p_q;
        n_d   = n_q;
        dly_d = dly_q;
        if ((p_q && !want_p) || (n_q && !want_n)) begin
            dly_d = deadtime_i;
            if (deadtime_i == '0) begin
                p_d = want_p;
                n_d = want_n;
            end else begin
                p_d = p_q && want_p;
                n_d = n_q && want_n;
            end
        end else begin
            if (dly_q != '0) dly_d = dly_q - 1'b1;
            if (dly_q <= DT_ONE) begin
                p_d = want_p && !n_q;
                n_d = want_n && !p_q;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            p_q   <= 1'b0;
            n_q   <= 1'b0;
            dly_q <= '0;
        end else begin
            p_q   <= p_d;
            n_q   <= n_d;
            dly_q <= dly_d;
        end
    end

    assign p_o = p_q;
    assign n_o = n_q;

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: shared prescaler/counter, double-buffered period and duties,
// edge- or center-aligned. Optional complementary outputs under PWM_DEADTIME_EN.
module pwm_multi_ch
    import pwm_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int PRESCALE_W = DEF_PRESCALE_W,
    parameter int DEADTIME_W = DEF_DEADTIME_W
) (
    input  logic                      clk_in,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [PRESCALE_W-1:0]     prescale,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic                      duty_load,
    input  logic                      center_mode,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_tick,
    output logic                      load_pending
`ifdef PWM_DEADTIME_EN
    ,
    input  logic [DEADTIME_W-1:0]     deadtime,
    output logic [CHANNELS-1:0]       pwm_n_out
`endif
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [PRESCALE_W-1:0]           pre_cnt_q, pre_cnt_d;
    logic [WIDTH-1:0]                cnt_q, cnt_d;
    logic [WIDTH-1:0]                per_act_q, per_act_d;
    logic [WIDTH-1:0]                per_sh_q, per_sh_d;
    logic [CHANNELS-1:0][WIDTH-1:0]  duty_act_q, duty_act_d;
    logic [CHANNELS-1:0][WIDTH-1:0]  duty_sh_q, duty_sh_d;
    logic [CHANNELS-1:0][WIDTH-1:0]  duty_in;
    logic                            dir_q, dir_d;
    logic                            mode_act_q, mode_act_d;
    logic                            load_pending_q, load_pending_d;
    logic                            period_tick_q;
    logic [CHANNELS-1:0]             pwm_q, pwm_d;
    logic [SLICE_BUS_W-1:0]          duty_bus;
    logic                            tick;
    logic                            boundary;

    always_comb begin
        duty_bus = '0;
        duty_bus[CHANNELS*WIDTH-1:0] = duty;
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign duty_in[g] = WIDTH'(duty_slice(duty_bus, g, WIDTH));
        assign pwm_d[g]   = enable && (cnt_q < duty_act_q[g]);
    end

    assign tick = enable && (pre_cnt_q == prescale);

    always_comb begin
        pre_cnt_d      = pre_cnt_q;
        cnt_d          = cnt_q;
        dir_d          = dir_q;
        per_act_d      = per_act_q;
        per_sh_d       = per_sh_q;
        duty_act_d     = duty_act_q;
        duty_sh_d      = duty_sh_q;
        mode_act_d     = mode_act_q;
        load_pending_d = load_pending_q;
        boundary       = 1'b0;

        if (!enable) begin
            // Stopped: counter parked at its start point, loads land in the active set.
            pre_cnt_d = '0;
            cnt_d     = '0;
            dir_d     = DIR_UP;
            if (duty_load) begin
                per_act_d  = period;
                duty_act_d = duty_in;
                per_sh_d   = period;
                duty_sh_d  = duty_in;
                mode_act_d = center_mode;
            end else if (load_pending_q) begin
                per_act_d  = per_sh_q;
                duty_act_d = duty_sh_q;
            end
            load_pending_d = 1'b0;
        end else begin
            pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
            if (tick) begin
                if (mode_act_q == MODE_CENTER) begin
                    if (dir_q == DIR_UP && cnt_q != per_act_q) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (cnt_q <= CNT_ONE) begin
                        boundary = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                        dir_d = DIR_DOWN;
                    end
                end else if (cnt_q == per_act_q) begin
                    boundary = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            if (boundary) begin
                cnt_d      = '0;
                dir_d      = DIR_UP;
                mode_act_d = center_mode;
                if (duty_load) begin
                    per_act_d  = period;
                    duty_act_d = duty_in;
                end else if (load_pending_q) begin
                    per_act_d  = per_sh_q;
                    duty_act_d = duty_sh_q;
                end
                load_pending_d = 1'b0;
            end else if (duty_load) begin
                per_sh_d       = period;
                duty_sh_d      = duty_in;
                load_pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q      <= '0;
            cnt_q          <= '0;
            dir_q          <= DIR_UP;
            per_act_q      <= '1;
            per_sh_q       <= '0;
            duty_act_q     <= '0;
            duty_sh_q      <= '0;
            mode_act_q     <= MODE_EDGE;
            load_pending_q <= 1'b0;
            period_tick_q  <= 1'b0;
            pwm_q          <= '0;
        end else begin
            pre_cnt_q      <= pre_cnt_d;
            cnt_q          <= cnt_d;
            dir_q          <= dir_d;
            per_act_q      <= per_act_d;
            per_sh_q       <= per_sh_d;
            duty_act_q     <= duty_act_d;
            duty_sh_q      <= duty_sh_d;
            mode_act_q     <= mode_act_d;
            load_pending_q <= load_pending_d;
            period_tick_q  <= boundary;
            pwm_q          <= pwm_d;
        end
    end

    assign period_tick  = period_tick_q;
    assign load_pending = load_pending_q;

`ifdef PWM_DEADTIME_EN
    for (genvar g = 0; g < CHANNELS; g++) begin : g_dt
        pwm_deadtime #(
            .DEADTIME_W (DEADTIME_W)
        ) u_dt (
            .clk_in     (clk_in),
            .rst_n      (rst_n),
            .enable_i   (enable),
            .deadtime_i (deadtime),
            .pwm_i      (pwm_q[g]),
            .p_o        (pwm_out[g]),
            .n_o        (pwm_n_out[g])
        );
    end
`else
    logic [DEADTIME_W-1:0] dt_unused;
    assign dt_unused = '0;
    assign pwm_out   = pwm_q;
`endif

endmodule
